// File: rtl/core_test_pkg.sv
// core_test_pkg: shared defaults and FSM state encoding for the core test
// controller and its scan checker.
package core_test_pkg;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_NUM_REGS   = 32;
  localparam int unsigned DEF_ADDR_W     = 5;
  localparam int unsigned DEF_RST_CYCLES = 1;
  localparam int unsigned DEF_TIMEOUT    = 40;
  localparam int unsigned DEF_CNT_W      = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_RST  = 3'd1;
  localparam state_t ST_RUN  = 3'd2;
  localparam state_t ST_SCAN = 3'd3;
  localparam state_t ST_DONE = 3'd4;

endpackage

// File: rtl/scan_checker.sv
// scan_checker: compare/accumulate stage of the register scan.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   clear            - synchronous clear of results (new test accepted)
//   valid, index     - a returned register word is present for this index
//   rdata, expected  - register contents and expected value
//   mask             - 1 = don't care, skip this index
//   fail_count       - number of mismatching registers
//   first_fail       - lowest mismatching index (indices arrive in order)
module scan_checker
  import core_test_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              valid,
  input  logic [ADDR_W-1:0] index,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] expected,
  input  logic              mask,
  output logic [ADDR_W:0]   fail_count,
  output logic [ADDR_W-1:0] first_fail
);

  logic              w_miss;
  logic [ADDR_W:0]   r_fail_count;
  logic [ADDR_W-1:0] r_first_fail;

  assign w_miss = valid && !mask && (rdata != expected);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_fail_count <= '0;
      r_first_fail <= '0;
    end else if (w_miss) begin
      r_fail_count <= r_fail_count + (ADDR_W+1)'(1);
      // Indices arrive in ascending order, so the first miss is the lowest.
      if (r_fail_count == '0) r_first_fail <= index;
    end
  end

  assign fail_count = r_fail_count;
  assign first_fail = r_first_fail;

endmodule

// File: rtl/core_test_ctrl.sv
// core_test_ctrl: resets a core under test, lets it run until halt or a
// cycle timeout, then scans its register file against an expected table.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   start                 - begin a test (accepted in IDLE or DONE only)
//   halt                  - core reached end of program
//   core_reset            - reset to the core (high in IDLE and RST)
//   dbg_addr / dbg_rdata  - register debug read, data one cycle later
//   exp_addr / exp_data / exp_mask - expected table read, same timing
//   done, pass, timed_out - test status
//   fail_count, first_fail, run_cycles - test results
module core_test_ctrl
  import core_test_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  output logic              core_reset,
  output logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              exp_mask,
  output logic              done,
  output logic              pass,
  output logic              timed_out,
  output logic [ADDR_W:0]   fail_count,
  output logic [ADDR_W-1:0] first_fail,
  output logic [CNT_W-1:0]  run_cycles
);

  localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t            r_state;
  logic [RCW-1:0]    r_rst_cnt;
  logic [ADDR_W:0]   r_scan_idx;
  logic [CNT_W-1:0]  r_run_cycles;
  logic              r_timed_out;
  logic              r_cmp_valid;
  logic [ADDR_W-1:0] r_cmp_idx;

  logic              w_start_ok;
  logic              w_scan_issue;
  logic [CNT_W-1:0]  w_run_next;
  logic              w_timeout;

  assign w_start_ok   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_scan_issue = (r_state == ST_SCAN) && (r_scan_idx < (ADDR_W+1)'(NUM_REGS));
  assign w_run_next   = (&r_run_cycles) ? r_run_cycles : r_run_cycles + CNT_W'(1);
  // Counts the current RUN cycle, so the exit cycle is included in run_cycles.
  assign w_timeout    = 32'(w_run_next) >= TIMEOUT;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_rst_cnt    <= '0;
      r_scan_idx   <= '0;
      r_run_cycles <= '0;
      r_timed_out  <= 1'b0;
      r_cmp_valid  <= 1'b0;
      r_cmp_idx    <= '0;
    end else begin
      r_cmp_valid <= w_scan_issue;
      r_cmp_idx   <= r_scan_idx[ADDR_W-1:0];
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_ok) begin
            r_state      <= ST_RST;
            r_rst_cnt    <= '0;
            r_run_cycles <= '0;
            r_timed_out  <= 1'b0;
          end
        end
        ST_RST: begin
          if (r_rst_cnt == RCW'(RST_CYCLES - 1)) r_state <= ST_RUN;
          else                                   r_rst_cnt <= r_rst_cnt + RCW'(1);
        end
        ST_RUN: begin
          r_run_cycles <= w_run_next;
          // halt has priority over a coincident timeout
          if (halt || w_timeout) begin
            r_state     <= ST_SCAN;
            r_scan_idx  <= '0;
            r_timed_out <= !halt;
          end
        end
        ST_SCAN: begin
          // one extra cycle drains the last compare out of the pipeline
          if (r_scan_idx == (ADDR_W+1)'(NUM_REGS)) r_state <= ST_DONE;
          else                                     r_scan_idx <= r_scan_idx + (ADDR_W+1)'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  scan_checker #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_checker (
    .clk        (clk),
    .reset      (reset),
    .clear      (w_start_ok),
    .valid      (r_cmp_valid),
    .index      (r_cmp_idx),
    .rdata      (dbg_rdata),
    .expected   (exp_data),
    .mask       (exp_mask),
    .fail_count (fail_count),
    .first_fail (first_fail)
  );

  assign dbg_addr   = w_scan_issue ? r_scan_idx[ADDR_W-1:0] : '0;
  assign exp_addr   = dbg_addr;
  assign core_reset = (r_state == ST_IDLE) || (r_state == ST_RST);
  assign done       = (r_state == ST_DONE);
  assign pass       = done && (fail_count == '0) && !r_timed_out;
  assign timed_out  = r_timed_out;
  assign run_cycles = r_run_cycles;

endmodule

// File: tb/tb_core_test_ctrl.sv
module tb_core_test_ctrl;
  localparam int NR = 32;
  localparam int TO = 40;
  localparam int RC = 3;

  logic        clk = 1'b0;
  logic        reset, start, halt;
  logic        core_reset, done, pass, timed_out, exp_mask;
  logic [4:0]  dbg_addr, exp_addr, first_fail;
  logic [31:0] dbg_rdata, exp_data;
  logic [5:0]  fail_count;
  logic [15:0] run_cycles;

  logic [31:0] regs [NR];
  logic [31:0] expv [NR];
  logic        maskv[NR];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  core_test_ctrl #(
    .DATA_W     (32),
    .NUM_REGS   (NR),
    .ADDR_W     (5),
    .RST_CYCLES (RC),
    .TIMEOUT    (TO),
    .CNT_W      (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .halt       (halt),
    .core_reset (core_reset),
    .dbg_addr   (dbg_addr),
    .dbg_rdata  (dbg_rdata),
    .exp_addr   (exp_addr),
    .exp_data   (exp_data),
    .exp_mask   (exp_mask),
    .done       (done),
    .pass       (pass),
    .timed_out  (timed_out),
    .fail_count (fail_count),
    .first_fail (first_fail),
    .run_cycles (run_cycles)
  );

  // Register file and expected table: synchronous read, data one cycle later.
  always @(posedge clk) begin
    dbg_rdata <= regs[dbg_addr];
    exp_data  <= expv[exp_addr];
    exp_mask  <= maskv[exp_addr];
  end

  typedef struct {
    int halt_at;  // RUN cycle carrying halt, 0 = never
    int bad_a;
    int bad_b;
    int mask_i;   // index that differs but is masked
    bit poke;     // start pulse during RUN
    int efc;
    int eff;
    int erc;
    bit eto;
    bit epass;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int bad_a, input int bad_b, input int mask_i, input bit rnd);
    for (int i = 0; i < NR; i++) begin
      regs[i]  = $urandom;
      expv[i]  = regs[i];
      maskv[i] = 1'b0;
      if (rnd) begin
        if ($urandom_range(0, 3) == 0) expv[i] = regs[i] ^ (32'h1 << $urandom_range(0, 31));
        if ($urandom_range(0, 3) == 0) maskv[i] = 1'b1;
      end
    end
    if (bad_a >= 0) expv[bad_a] = ~regs[bad_a];
    if (bad_b >= 0) expv[bad_b] = ~regs[bad_b];
    if (mask_i >= 0) begin
      expv[mask_i]  = ~regs[mask_i];
      maskv[mask_i] = 1'b1;
    end
  endtask

  // Reference: count unmasked differences, remember the lowest index.
  task automatic model(output int fc, output int ff);
    fc = 0;
    ff = 0;
    for (int i = 0; i < NR; i++)
      if (!maskv[i] && regs[i] != expv[i]) begin
        if (fc == 0) ff = i;
        fc++;
      end
  endtask

  task automatic run_test(input string tag, input vec_t v);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ".clr_done"}, done, 0);
    chk({tag, ".clr_fail_count"}, fail_count, 0);
    chk({tag, ".clr_run_cycles"}, run_cycles, 0);
    chk({tag, ".clr_timed_out"}, timed_out, 0);
    for (int i = 0; i < RC; i++) begin
      chk({tag, ".core_reset_hi"}, core_reset, 1);
      tick();
    end
    chk({tag, ".core_reset_lo"}, core_reset, 0);
    for (int cyc = 1; cyc <= TO; cyc++) begin
      chk({tag, ".run_addr0"}, dbg_addr, 0);
      halt  = (cyc == v.halt_at);
      start = v.poke && (cyc == 2);
      tick();
      halt  = 1'b0;
      start = 1'b0;
      if (cyc == v.halt_at) break;
    end
    for (int k = 0; k <= NR; k++) begin
      chk({tag, ".scan_addr"}, dbg_addr, (k < NR) ? k : 0);
      chk({tag, ".scan_busy"}, done, 0);
      tick();
    end
    chk({tag, ".done"}, done, 1);
    chk({tag, ".pass"}, pass, v.epass);
    chk({tag, ".fail_count"}, fail_count, v.efc);
    chk({tag, ".first_fail"}, first_fail, v.eff);
    chk({tag, ".run_cycles"}, run_cycles, v.erc);
    chk({tag, ".timed_out"}, timed_out, v.eto);
    chk({tag, ".core_reset_done"}, core_reset, 0);
    tick();
    chk({tag, ".done_held"}, done, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".core_reset"}, core_reset, 1);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".pass"}, pass, 0);
    chk({tag, ".timed_out"}, timed_out, 0);
    chk({tag, ".fail_count"}, fail_count, 0);
    chk({tag, ".first_fail"}, first_fail, 0);
    chk({tag, ".run_cycles"}, run_cycles, 0);
    chk({tag, ".dbg_addr"}, dbg_addr, 0);
  endtask

  vec_t tbl[7];

  initial begin
    vec_t v;
    int   fc, ff;

    tbl[0] = '{12, -1, -1, -1, 1'b0, 0, 0, 12, 1'b0, 1'b1};
    tbl[1] = '{20,  3,  9, -1, 1'b0, 2, 3, 20, 1'b0, 1'b0};
    tbl[2] = '{ 0, -1, -1, -1, 1'b0, 0, 0, 40, 1'b1, 1'b0};
    tbl[3] = '{ 7, -1, -1,  5, 1'b0, 0, 0,  7, 1'b0, 1'b1};
    tbl[4] = '{40, -1, -1, -1, 1'b0, 0, 0, 40, 1'b0, 1'b1};
    tbl[5] = '{ 1,  0, 31, -1, 1'b0, 2, 0,  1, 1'b0, 1'b0};
    tbl[6] = '{15, -1, -1, -1, 1'b1, 0, 0, 15, 1'b0, 1'b1};

    reset = 1'b1;
    start = 1'b0;
    halt  = 1'b0;
    load(-1, -1, -1, 1'b0);
    tick();
    tick();
    check_reset_vals("por");
    reset = 1'b0;
    tick();
    check_reset_vals("idle");

    for (int t = 0; t < 7; t++) begin
      load(tbl[t].bad_a, tbl[t].bad_b, tbl[t].mask_i, 1'b0);
      run_test($sformatf("vec%0d", t), tbl[t]);
    end

    // Reset in the middle of SCAN, with mismatches already counted.
    load(2, 10, -1, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < RC; i++) tick();
    for (int cyc = 1; cyc <= 5; cyc++) begin
      halt = (cyc == 5);
      tick();
      halt = 1'b0;
    end
    for (int k = 0; k < 10; k++) tick();
    chk("mid_scan.addr", dbg_addr, 10);
    chk("mid_scan.partial", fail_count, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_vals("scan_rst");
    tick();
    check_reset_vals("scan_rst_settle");
    load(-1, -1, -1, 1'b0);
    v = '{5, -1, -1, -1, 1'b0, 0, 0, 5, 1'b0, 1'b1};
    run_test("after_rst", v);

    // Randomized tests against the reference model.
    for (int t = 0; t < 20; t++) begin
      load(-1, -1, -1, 1'b1);
      model(fc, ff);
      v.halt_at = $urandom_range(0, TO);
      v.bad_a   = -1;
      v.bad_b   = -1;
      v.mask_i  = -1;
      v.poke    = $urandom_range(0, 1) == 1;
      v.efc     = fc;
      v.eff     = ff;
      v.erc     = (v.halt_at == 0) ? TO : v.halt_at;
      v.eto     = (v.halt_at == 0);
      v.epass   = (fc == 0) && (v.halt_at != 0);
      run_test($sformatf("rnd%0d", t), v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/core_test_ctrl.md
CORE_TEST_CTRL -- requirements
Module: core_test_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of a register and an expected value.
REQ-002 SHALL have parameter NUM_REGS, default 32, number of architectural registers scanned.
REQ-003 SHALL have parameter ADDR_W, default 5, register index width, with ceil(log2(NUM_REGS)) <= ADDR_W.
REQ-004 SHALL have parameter RST_CYCLES, default 1, number of cycles core_reset is held, minimum 1.
REQ-005 SHALL have parameter TIMEOUT, default 40, number of run cycles allowed before a forced stop.
REQ-006 SHALL have parameter CNT_W, default 16, width of the run-cycle counter.
REQ-007 clk  in  1  single clock; all state updates on the rising edge.
REQ-008 reset  in  1  reset, synchronous, active-high.
REQ-009 start  in  1  one-cycle pulse that begins a test; ignored unless in IDLE or DONE.
REQ-010 halt  in  1  core signals end of program (for example ecall/ebreak retired).
REQ-011 core_reset  out  1  synchronous reset driven to the core under test.
REQ-012 dbg_addr  out  ADDR_W  register-file debug read index.
REQ-013 dbg_rdata  in  DATA_W  debug read data, valid one cycle after dbg_addr.
REQ-014 exp_addr  out  ADDR_W  expected-value table index; always equal to dbg_addr.
REQ-015 exp_data  in  DATA_W  expected value, valid one cycle after exp_addr.
REQ-016 exp_mask  in  1  don't-care flag, 1 = skip the compare; same timing as exp_data.
REQ-017 done  out  1  test finished, held until the next start or reset.
REQ-018 pass  out  1  valid while done=1; 1 means no mismatch and no timeout.
REQ-019 timed_out  out  1  run phase ended by TIMEOUT, not by halt.
REQ-020 fail_count  out  ADDR_W+1  number of mismatching registers.
REQ-021 first_fail  out  ADDR_W  index of the lowest mismatching register.
REQ-022 run_cycles  out  CNT_W  cycles spent in RUN.

Function
REQ-023 The FSM SHALL have five states: IDLE, RST, RUN, SCAN, DONE.
REQ-024 IDLE->RST on start; RST SHALL assert core_reset for exactly RST_CYCLES cycles, then move to RUN.
REQ-025 RUN SHALL count run_cycles each cycle and leave to SCAN on halt=1.
REQ-026 RUN SHALL also leave to SCAN when run_cycles reaches TIMEOUT, setting timed_out.
REQ-027 If halt and timeout occur in the same cycle, halt SHALL win and timed_out SHALL stay 0.
REQ-028 run_cycles SHALL saturate at its maximum value and never wrap.
REQ-029 SCAN SHALL issue dbg_addr = 0..NUM_REGS-1, one per cycle.
REQ-030 SCAN SHALL compare each returned word one cycle later (pipelined), skipping any index whose exp_mask=1.
REQ-031 SCAN SHALL last NUM_REGS+1 cycles, then move to DONE.
REQ-032 Each mismatch SHALL increment fail_count; first_fail SHALL latch on the first mismatch only.
REQ-033 Register index 0 SHALL be compared like any other index.
REQ-034 In DONE, pass SHALL equal (fail_count==0) && !timed_out.
REQ-035 A start pulse in DONE SHALL clear all results and go to RST.
REQ-036 A start pulse in RST, RUN or SCAN SHALL be ignored.
REQ-037 dbg_addr SHALL hold 0 outside SCAN.
REQ-038 core_reset SHALL be 1 in IDLE and RST, and 0 in RUN, SCAN and DONE.
REQ-039 The core SHALL be frozen during SCAN only by the halt it raised; the controller SHALL NOT gate the core clock.

Reset
REQ-040 On reset=1 at a clock edge, regardless of state, the controller SHALL enter IDLE.
REQ-041 Reset values SHALL be: core_reset=1, done=0, pass=0, timed_out=0, fail_count=0, first_fail=0, run_cycles=0, dbg_addr=0.
REQ-042 Reset during SCAN SHALL discard partial results, and the scan pipeline valid bit SHALL clear.

Structure
REQ-043 The state encoding and the default parameter values SHALL live in shared package core_test_pkg.
REQ-044 The pipelined compare/accumulate stage SHALL be sub-module scan_checker (inputs: valid, index, rdata, expected, mask; outputs: fail_count, first_fail).
REQ-045 Implementation SHALL be synthesizable, with no delays and no system tasks.

Verification
REQ-046 Matching model, halt at cycle 12 -> done=1, pass=1, fail_count=0, run_cycles=12, timed_out=0.
REQ-047 Regs 3 and 9 differ from expected, halt at 20 -> pass=0, fail_count=2, first_fail=3.
REQ-048 halt never asserted, TIMEOUT=40 -> timed_out=1, pass=0, run_cycles=40, scan still completes.
REQ-049 Reg 5 differs but exp_mask[5]=1 -> pass=1, fail_count=0.
REQ-050 Reset pulse during SCAN at index 10 -> IDLE next cycle, all outputs at reset values; a new start gives a clean result.
REQ-051 RST_CYCLES=3 -> core_reset high for exactly 3 cycles after start; a start pulse during RUN has no effect.
